// File: rtl/alt_vipitc_avst_pkt_decoder_pkg.sv
// rtl/alt_vipitc_avst_pkt_decoder_pkg.sv - shared packet types, state encoding and header classification
package alt_vipitc_avst_pkt_decoder_pkg;

  localparam logic [3:0] TYPE_VIDEO = 4'd0;
  localparam logic [3:0] TYPE_ANC   = 4'd13;
  localparam logic [3:0] TYPE_CTRL  = 4'd15;

  // width (4) + height (4) + interlace (1) nibbles in a control packet
  localparam int NIBBLES_PER_CTRL = 9;

  typedef enum logic [2:0] {
    FIND_SOP = 3'd0,
    CTRL     = 3'd1,
    VIDEO    = 3'd2,
    ANC      = 3'd3,
    DISCARD  = 3'd4
  } state_t;

  // Next state after accepting a header beat; a header that also ends the packet is empty.
  function automatic state_t header_state(input logic [3:0] ptype, input logic eop,
                                          input logic embedded);
    state_t ns;
    case (ptype)
      TYPE_VIDEO: ns = VIDEO;
      TYPE_CTRL:  ns = CTRL;
      TYPE_ANC:   ns = embedded ? ANC : DISCARD;
      default:    ns = DISCARD;
    endcase
    if (eop) ns = FIND_SOP;
    return ns;
  endfunction

endpackage

// File: rtl/vipitc_nibble_unpack.sv
// rtl/vipitc_nibble_unpack.sv - picks control nibbles out of one beat and where they land
module vipitc_nibble_unpack
  import alt_vipitc_avst_pkt_decoder_pkg::*;
#(
  parameter int BPS = 8,
  parameter int CPP = 3
) (
  input  logic [3:0]         count,
  input  logic [BPS*CPP-1:0] din_data,
  output logic [15:0]        nibs,
  output logic [15:0]        idx,
  output logic [3:0]         nib_valid,
  output logic [3:0]         inc
);

  localparam logic [3:0] CPP4  = 4'(CPP);
  localparam logic [3:0] TOTAL = 4'(NIBBLES_PER_CTRL);

  logic [3:0] remaining;
  logic       unused_upper_bits;

  assign remaining = (count >= TOTAL) ? 4'd0 : TOTAL - count;
  assign inc       = (remaining < CPP4) ? remaining : CPP4;

  // only the low nibble of each symbol carries control information
  assign unused_upper_bits = ^din_data;

  for (genvar s = 0; s < 4; s++) begin : g_sym
    if (s < CPP) begin : g_used
      assign nibs[4*s +: 4] = din_data[s*BPS +: 4];
      assign idx[4*s +: 4]  = count + 4'(s);
      assign nib_valid[s]   = 4'(s) < inc;
    end else begin : g_absent
      assign nibs[4*s +: 4] = 4'd0;
      assign idx[4*s +: 4]  = 4'd0;
      assign nib_valid[s]   = 1'b0;
    end
  end

endmodule

// File: rtl/alt_vipitc_avst_pkt_decoder.sv
// rtl/alt_vipitc_avst_pkt_decoder.sv - Avalon-ST video packet classifier, control decoder and payload forwarder
module alt_vipitc_avst_pkt_decoder
  import alt_vipitc_avst_pkt_decoder_pkg::*;
#(
  parameter int BPS                = 8,
  parameter int CPP                = 3,
  parameter int USE_EMBEDDED_SYNCS = 0
) (
  input  logic               rst,
  input  logic               clk,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic [BPS*CPP-1:0] din_data,
  input  logic               din_sop,
  input  logic               din_eop,
  output logic               vid_valid,
  output logic               vid_sop,
  output logic               vid_eop,
  output logic [BPS*CPP-1:0] vid_data,
  output logic               vid_anc,
  input  logic               vid_ready,
  output logic [15:0]        ctrl_width,
  output logic [15:0]        ctrl_height,
  output logic [3:0]         ctrl_interlace,
  output logic               ctrl_update,
  output logic               ctrl_error,
  output logic [2:0]         state
);

  state_t     st;
  state_t     hdr_state;
  logic [3:0] count;
  logic       first;
  logic       in_payload;
  logic       accept;
  logic [3:0] shadow      [NIBBLES_PER_CTRL];
  logic [3:0] shadow_next [NIBBLES_PER_CTRL];
  logic [15:0] nibs;
  logic [15:0] idx;
  logic [3:0]  nib_valid;
  logic [3:0]  inc;

  vipitc_nibble_unpack #(.BPS(BPS), .CPP(CPP)) u_unpack (
    .count     (count),
    .din_data  (din_data),
    .nibs      (nibs),
    .idx       (idx),
    .nib_valid (nib_valid),
    .inc       (inc)
  );

  assign in_payload = (st == VIDEO) || (st == ANC);
  assign din_ready  = in_payload ? vid_ready : 1'b1;
  assign accept     = din_valid & din_ready;
  assign hdr_state  = header_state(din_data[3:0], din_eop, USE_EMBEDDED_SYNCS != 0);

  // a sop seen while forwarding aborts the packet: close it with eop and blank data
  assign vid_valid = in_payload & din_valid;
  assign vid_sop   = in_payload & first;
  assign vid_eop   = in_payload & (din_eop | din_sop);
  assign vid_data  = din_sop ? '0 : din_data;
  assign vid_anc   = (st == ANC);
  assign state     = st;

  // Merge this beat's nibbles into the shadow copy so the final beat is included on latch.
  always_comb begin
    shadow_next = shadow;
    for (int s = 0; s < 4; s++) begin
      if (nib_valid[s]) shadow_next[idx[4*s +: 4]] = nibs[4*s +: 4];
    end
  end

  // Packet FSM: classify headers, assemble control fields, track payload position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st             <= FIND_SOP;
      count          <= 4'd0;
      first          <= 1'b0;
      shadow         <= '{default: '0};
      ctrl_width     <= 16'd0;
      ctrl_height    <= 16'd0;
      ctrl_interlace <= 4'd0;
      ctrl_update    <= 1'b0;
      ctrl_error     <= 1'b0;
    end else begin
      ctrl_update <= 1'b0;
      ctrl_error  <= 1'b0;
      if (accept) begin
        if (din_sop) begin
          st    <= hdr_state;
          count <= 4'd0;
          first <= 1'b1;
          if (st == CTRL) ctrl_error <= 1'b1;
        end else begin
          case (st)
            CTRL: begin
              count  <= count + inc;
              shadow <= shadow_next;
              if (din_eop) begin
                st <= FIND_SOP;
                if ((count + inc) == 4'(NIBBLES_PER_CTRL)) begin
                  ctrl_width     <= {shadow_next[0], shadow_next[1], shadow_next[2], shadow_next[3]};
                  ctrl_height    <= {shadow_next[4], shadow_next[5], shadow_next[6], shadow_next[7]};
                  ctrl_interlace <= shadow_next[8];
                  ctrl_update    <= 1'b1;
                end else begin
                  ctrl_error <= 1'b1;
                end
              end
            end
            VIDEO, ANC: begin
              first <= 1'b0;
              if (din_eop) st <= FIND_SOP;
            end
            DISCARD: begin
              if (din_eop) st <= FIND_SOP;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
